// File: rtl/ampliacao_replicacao_pkg.sv
// Shared coprocessor definitions for the upscaling engine: default image
// geometry, FSM state encoding, pixel type and the scale-legality helper.
package ampliacao_replicacao_pkg;

    localparam int unsigned DEF_SRC_W      = 160;
    localparam int unsigned DEF_SRC_H      = 120;
    localparam int unsigned DEF_ESCALA_MAX = 4;
    localparam int unsigned DEF_ADDR_W     = 19;

    localparam int unsigned ESCALA_W = 3;
    localparam int unsigned PIXEL_W  = 8;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_FINISH
    } state_e;

    // A scale factor is usable when it is non-zero and no larger than max_e.
    function automatic logic escala_legal(input logic [ESCALA_W-1:0] e,
                                          input int unsigned         max_e);
        return (e != '0) && (32'(e) <= max_e);
    endfunction

endpackage

// File: rtl/ampliacao_replicacao_gerador_enderecos_amp.sv
// Address generator for nearest-neighbour upscaling.
// Holds the source pixel counters (sx, sy) and the in-block replication
// counters (dx, dy), and keeps running row bases so that source and
// destination addresses are produced with adders only.
// Ports:
//   clk, rst        clock, async active-high reset
//   clear_i         restart at pixel (0,0) and latch escala_i
//   adv_i           one destination write was accepted; step the counters
//   escala_i        scale factor, sampled on clear_i
//   src_addr_c_o    source address after this cycle's update
//   dst_addr_c_o    destination address after this cycle's update
//   last_block_c_o  current write is the last one of the e x e block
//   last_pixel_c_o  current source pixel is the last of the frame
module gerador_enderecos_amp
    import ampliacao_replicacao_pkg::*;
#(
    parameter int unsigned SRC_W      = DEF_SRC_W,
    parameter int unsigned SRC_H      = DEF_SRC_H,
    parameter int unsigned ESCALA_MAX = DEF_ESCALA_MAX,
    parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                adv_i,
    input  logic [ESCALA_W-1:0] escala_i,
    output logic [ADDR_W-1:0]   src_addr_c_o,
    output logic [ADDR_W-1:0]   dst_addr_c_o,
    output logic                last_block_c_o,
    output logic                last_pixel_c_o
);

    localparam int unsigned SX_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int unsigned SY_W = (SRC_H > 1) ? $clog2(SRC_H) : 1;

    logic [ESCALA_W-1:0] e_q, e_d;
    logic [ESCALA_W-1:0] dx_q, dx_d, dy_q, dy_d;
    logic [SX_W-1:0]     sx_q, sx_d;
    logic [SY_W-1:0]     sy_q, sy_d;
    logic [ADDR_W-1:0]   line_w_q, line_w_d;   // destination line width SRC_W*e
    logic [ADDR_W-1:0]   src_row_q, src_row_d; // sy*SRC_W
    logic [ADDR_W-1:0]   blk_row_q, blk_row_d; // (sy*e)*line_w
    logic [ADDR_W-1:0]   dst_row_q, dst_row_d; // (sy*e+dy)*line_w
    logic [ADDR_W-1:0]   dst_col_q, dst_col_d; // sx*e
    logic [ADDR_W-1:0]   line_w_calc;
    logic [ESCALA_W-1:0] e_last;

    assign e_last = e_q - ESCALA_W'(1);

    // SRC_W*escala built as a sum of constants instead of a multiplier.
    always_comb begin
        line_w_calc = '0;
        for (int unsigned k = 1; k <= ESCALA_MAX; k++) begin
            if (32'(escala_i) >= k) begin
                line_w_calc = line_w_calc + ADDR_W'(SRC_W);
            end
        end
    end

    // Counter and row-base update.
    always_comb begin
        e_d       = e_q;
        line_w_d  = line_w_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        src_row_d = src_row_q;
        blk_row_d = blk_row_q;
        dst_row_d = dst_row_q;
        dst_col_d = dst_col_q;
        if (clear_i) begin
            e_d       = escala_i;
            line_w_d  = line_w_calc;
            dx_d      = '0;
            dy_d      = '0;
            sx_d      = '0;
            sy_d      = '0;
            src_row_d = '0;
            blk_row_d = '0;
            dst_row_d = '0;
            dst_col_d = '0;
        end else if (adv_i) begin
            if (dx_q != e_last) begin
                dx_d = dx_q + ESCALA_W'(1);
            end else begin
                dx_d = '0;
                if (dy_q != e_last) begin
                    dy_d      = dy_q + ESCALA_W'(1);
                    dst_row_d = dst_row_q + line_w_q;
                end else begin
                    dy_d = '0;
                    if (sx_q != SX_W'(SRC_W - 1)) begin
                        sx_d      = sx_q + SX_W'(1);
                        dst_col_d = dst_col_q + ADDR_W'(e_q);
                        dst_row_d = blk_row_q;
                    end else begin
                        // dst_row_q sits on the block's last line here, so
                        // one more line width lands on the next block row.
                        sx_d      = '0;
                        sy_d      = sy_q + SY_W'(1);
                        src_row_d = src_row_q + ADDR_W'(SRC_W);
                        dst_col_d = '0;
                        blk_row_d = dst_row_q + line_w_q;
                        dst_row_d = dst_row_q + line_w_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q       <= '0;
            line_w_q  <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            src_row_q <= '0;
            blk_row_q <= '0;
            dst_row_q <= '0;
            dst_col_q <= '0;
        end else begin
            e_q       <= e_d;
            line_w_q  <= line_w_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            src_row_q <= src_row_d;
            blk_row_q <= blk_row_d;
            dst_row_q <= dst_row_d;
            dst_col_q <= dst_col_d;
        end
    end

    // Addresses are taken from the next-state values so the FSM can register
    // them on the same edge that advances the counters.
    assign src_addr_c_o   = src_row_d + ADDR_W'(sx_d);
    assign dst_addr_c_o   = dst_row_d + dst_col_d + ADDR_W'(dx_d);
    assign last_block_c_o = (dx_q == e_last) && (dy_q == e_last);
    assign last_pixel_c_o = (sx_q == SX_W'(SRC_W - 1)) && (sy_q == SY_W'(SRC_H - 1));

endmodule

// File: rtl/ampliacao_replicacao.sv
// Nearest-neighbour upscaling engine: reads each source pixel once and
// writes it escala x escala times into the destination frame buffer.
// Ports:
//   clk, rst              clock, async active-high reset
//   start, escala         job request (sampled in IDLE) and scale factor
//   rd_en, rd_addr        source RAM read strobe and address
//   rd_data               source pixel, valid the cycle after rd_en
//   wr_en, wr_addr,
//   wr_data, wr_ready     destination write request with backpressure
//   busy, done, error     job status; error pulses with done on bad escala
module ampliacao_replicacao
    import ampliacao_replicacao_pkg::*;
#(
    parameter int unsigned SRC_W      = DEF_SRC_W,
    parameter int unsigned SRC_H      = DEF_SRC_H,
    parameter int unsigned ESCALA_MAX = DEF_ESCALA_MAX,
    parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ESCALA_W-1:0] escala,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  pixel_t              rd_data,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output pixel_t              wr_data,
    input  logic                wr_ready,
    output logic                busy,
    output logic                done,
    output logic                error
);

    state_e              state_q;
    logic                rd_en_q, wr_en_q, busy_q, done_q, error_q;
    logic [ADDR_W-1:0]   rd_addr_q, wr_addr_q;
    pixel_t              wr_data_q;

    logic                start_ok_c;
    logic                clear_c;
    logic                adv_c;
    logic [ADDR_W-1:0]   src_addr_c;
    logic [ADDR_W-1:0]   dst_addr_c;
    logic                last_block_c;
    logic                last_pixel_c;

    assign start_ok_c = start && escala_legal(escala, ESCALA_MAX);
    assign clear_c    = (state_q == ST_IDLE) && start_ok_c;
    assign adv_c      = (state_q == ST_WRITE) && wr_ready;

    gerador_enderecos_amp #(
        .SRC_W      (SRC_W),
        .SRC_H      (SRC_H),
        .ESCALA_MAX (ESCALA_MAX),
        .ADDR_W     (ADDR_W)
    ) u_gerador (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (clear_c),
        .adv_i          (adv_c),
        .escala_i       (escala),
        .src_addr_c_o   (src_addr_c),
        .dst_addr_c_o   (dst_addr_c),
        .last_block_c_o (last_block_c),
        .last_pixel_c_o (last_pixel_c)
    );

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (start_ok_c) begin
                            state_q   <= ST_READ;
                            busy_q    <= 1'b1;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= src_addr_c;
                        end else begin
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    rd_en_q <= 1'b0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Source RAM data lands now; it is the pixel for the whole block.
                    wr_data_q <= rd_data;
                    wr_addr_q <= dst_addr_c;
                    wr_en_q   <= 1'b1;
                    state_q   <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (wr_ready) begin
                        if (last_block_c) begin
                            wr_en_q <= 1'b0;
                            if (last_pixel_c) begin
                                state_q <= ST_FINISH;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q   <= ST_READ;
                                rd_en_q   <= 1'b1;
                                rd_addr_q <= src_addr_c;
                            end
                        end else begin
                            wr_addr_q <= dst_addr_c;
                        end
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;

endmodule

// File: tb/tb_ampliacao_replicacao.sv
// Bench for ampliacao_replicacao on a 4x2 source image: a scoreboard of
// expected reads and writes is filled when each job is started and drained
// by a monitor as the design issues them.
module tb_ampliacao_replicacao;
    import ampliacao_replicacao_pkg::*;

    localparam int unsigned W    = 4;
    localparam int unsigned H    = 2;
    localparam int unsigned EMAX = 4;
    localparam int unsigned AW   = 19;
    localparam int unsigned NPIX = W * H;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [2:0]    escala;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic          busy;
    logic          done;
    logic          error;

    logic [7:0]    src_mem [NPIX];
    wr_t           exp_wr[$];
    int            exp_rd[$];
    int            hits_5a[$];

    int checks, errors;
    int wr_cnt, rd_cnt, done_cnt, err_cnt, busy_cnt;
    logic [AW-1:0] last_addr;
    logic [7:0]    last_data;

    ampliacao_replicacao #(
        .SRC_W      (W),
        .SRC_H      (H),
        .ESCALA_MAX (EMAX),
        .ADDR_W     (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .escala   (escala),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Source RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= src_mem[rd_addr[2:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_en"},   32'(rd_en),   0);
        check({tag, "_wr_en"},   32'(wr_en),   0);
        check({tag, "_busy"},    32'(busy),    0);
        check({tag, "_done"},    32'(done),    0);
        check({tag, "_error"},   32'(error),   0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 0);
        check({tag, "_wr_data"}, 32'(wr_data), 0);
    endtask

    // Expected read and write stream for a whole job at scale e.
    task automatic push_job(input int e);
        wr_t w;
        for (int sy = 0; sy < int'(H); sy++) begin
            for (int sx = 0; sx < int'(W); sx++) begin
                exp_rd.push_back(sy * int'(W) + sx);
                for (int dy = 0; dy < e; dy++) begin
                    for (int dx = 0; dx < e; dx++) begin
                        w.addr = AW'((sy * e + dy) * (int'(W) * e) + sx * e + dx);
                        w.data = src_mem[sy * int'(W) + sx];
                        exp_wr.push_back(w);
                    end
                end
            end
        end
    endtask

    // Samples mid-cycle and drains the scoreboard.
    task automatic monitor();
        wr_t w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (busy)  busy_cnt++;
                if (done)  done_cnt++;
                if (error) err_cnt++;
                if (rd_en) begin
                    rd_cnt++;
                    if (exp_rd.size() == 0) check("rd_unexpected", 32'(rd_addr), 32'hFFFF_FFFF);
                    else                    check("rd_addr", 32'(rd_addr), 32'(exp_rd.pop_front()));
                end
                if (wr_en && wr_ready) begin
                    wr_cnt++;
                    last_addr = wr_addr;
                    last_data = wr_data;
                    if (wr_data == 8'h5A) hits_5a.push_back(int'(wr_addr));
                    if (exp_wr.size() == 0) begin
                        check("wr_unexpected", 32'(wr_addr), 32'hFFFF_FFFF);
                    end else begin
                        w = exp_wr.pop_front();
                        check("wr_addr", 32'(wr_addr), 32'(w.addr));
                        check("wr_data", 32'(wr_data), 32'(w.data));
                    end
                end
            end
        end
    endtask

    // Pulse start at the current cycle T and check the first cycles of the job.
    task automatic start_job(input logic [2:0] e, input bit legal);
        start  = 1'b1;
        escala = e;
        @(posedge clk); #1;
        start = 1'b0;
        if (legal) begin
            check("t1_busy",    32'(busy),    1);
            check("t1_rd_en",   32'(rd_en),   1);
            check("t1_rd_addr", 32'(rd_addr), 0);
            check("t1_wr_en",   32'(wr_en),   0);
            @(posedge clk); #1;
            check("t2_rd_en",   32'(rd_en),   0);
            check("t2_wr_en",   32'(wr_en),   0);
            @(posedge clk); #1;
            check("t3_wr_en",   32'(wr_en),   1);
            check("t3_wr_addr", 32'(wr_addr), 0);
            check("t3_wr_data", 32'(wr_data), 32'(src_mem[0]));
        end else begin
            check("bad_error", 32'(error), 1);
            check("bad_done",  32'(done),  1);
            check("bad_busy",  32'(busy),  0);
            check("bad_rd_en", 32'(rd_en), 0);
            @(posedge clk); #1;
            check("bad_error_pulse", 32'(error), 0);
            check("bad_done_pulse",  32'(done),  0);
        end
    endtask

    // Wait for done within a cycle budget, then step back into IDLE.
    task automatic wait_done(input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen",      32'(done),  1);
        check("busy_with_done", 32'(busy),  0);
        check("error_clean",    32'(error), 0);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 0);
    endtask

    task automatic wait_wr(input int target, input int limit);
        int n = 0;
        while (wr_cnt < target && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("wr_poll", 32'(wr_cnt), 32'(target));
    endtask

    initial begin
        int wb, rb, db, eb, bb;
        clk = 1'b0; rst = 1'b1; start = 1'b0; escala = '0; wr_ready = 1'b1;
        checks = 0; errors = 0;
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0;
        last_addr = '0; last_data = '0;
        for (int i = 0; i < int'(NPIX); i++) src_mem[i] = 8'(i);
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Plain copy: write address equals pixel index equals data.
        wb = wr_cnt; db = done_cnt; eb = err_cnt;
        push_job(1);
        start_job(3'd1, 1'b1);
        wait_done(200);
        check("copy_writes", 32'(wr_cnt - wb),   8);
        check("copy_done",   32'(done_cnt - db), 1);
        check("copy_error",  32'(err_cnt - eb),  0);
        check("copy_q_wr",   32'(exp_wr.size()), 0);
        check("copy_q_rd",   32'(exp_rd.size()), 0);

        // 2x replication with a marker pixel at (1,0).
        for (int i = 0; i < int'(NPIX); i++) src_mem[i] = 8'(8'h10 + i);
        src_mem[1] = 8'h5A;
        hits_5a.delete();
        wb = wr_cnt; bb = busy_cnt;
        push_job(2);
        start_job(3'd2, 1'b1);
        wait_done(200);
        check("x2_writes", 32'(wr_cnt - wb),   32);
        check("x2_busy",   32'(busy_cnt - bb), 48);
        check("x2_hits",   32'(hits_5a.size()), 4);
        if (hits_5a.size() == 4) begin
            check("x2_hit0", 32'(hits_5a[0]), 2);
            check("x2_hit1", 32'(hits_5a[1]), 3);
            check("x2_hit2", 32'(hits_5a[2]), 10);
            check("x2_hit3", 32'(hits_5a[3]), 11);
        end

        // Illegal scale factors.
        wb = wr_cnt; rb = rd_cnt; db = done_cnt; eb = err_cnt; bb = busy_cnt;
        start_job(3'd0, 1'b0);
        start_job(3'd5, 1'b0);
        check("bad_writes", 32'(wr_cnt - wb),   0);
        check("bad_reads",  32'(rd_cnt - rb),   0);
        check("bad_busy",   32'(busy_cnt - bb), 0);
        check("bad_dones",  32'(done_cnt - db), 2);
        check("bad_errors", 32'(err_cnt - eb),  2);

        // Backpressure on the second write of the first block.
        wb = wr_cnt; bb = busy_cnt;
        push_job(2);
        start_job(3'd2, 1'b1);
        wait_wr(wb + 1, 50);
        wr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("stall_wr_en",   32'(wr_en),   1);
            check("stall_wr_addr", 32'(wr_addr), 1);
            check("stall_wr_data", 32'(wr_data), 32'(src_mem[0]));
            if (k < 3) begin
                @(posedge clk); #1;
            end
        end
        wr_ready = 1'b1;
        wait_done(200);
        check("stall_writes", 32'(wr_cnt - wb),   32);
        check("stall_busy",   32'(busy_cnt - bb), 51);
        check("stall_q_wr",   32'(exp_wr.size()), 0);

        // Reset in the middle of WRITE, then a fresh 3x job with a stray start.
        wb = wr_cnt;
        push_job(2);
        start_job(3'd2, 1'b1);
        wait_wr(wb + 2, 50);
        rst = 1'b1;
        #1;
        check_outputs_zero("abort");
        exp_wr.delete();
        exp_rd.delete();
        db = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'(db));
        wb = wr_cnt;
        push_job(3);
        start_job(3'd3, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        start  = 1'b1;
        escala = 3'd1;
        @(posedge clk); #1;
        start = 1'b0;
        check("misuse_busy", 32'(busy), 1);
        wait_done(300);
        check("x3_writes", 32'(wr_cnt - wb),   72);
        check("x3_done",   32'(done_cnt - db), 1);
        check("x3_q_wr",   32'(exp_wr.size()), 0);

        // Largest scale: last destination address of the frame.
        for (int i = 0; i < int'(NPIX); i++) src_mem[i] = 8'($urandom_range(0, 255));
        wb = wr_cnt; rb = rd_cnt;
        push_job(4);
        start_job(3'd4, 1'b1);
        wait_done(400);
        check("x4_writes",    32'(wr_cnt - wb), 128);
        check("x4_reads",     32'(rd_cnt - rb), 8);
        check("x4_last_addr", 32'(last_addr),   127);
        check("x4_last_data", 32'(last_data),   32'(src_mem[NPIX-1]));
        check("x4_q_wr",      32'(exp_wr.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
